// File: rtl/ffd_delay_line_sync_reset_if.sv
// Bus bundle for the enable-gated delay line.
// The block drives the tap outputs. Everything else comes from the client side.
interface ffd_delay_line_sync_reset_if #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 4,
  parameter int TAP_W = $clog2(DEPTH + 1)
);
  logic             Enable;
  logic             Flush;
  logic             iValid;
  logic [SIZE-1:0]  D;
  logic [TAP_W-1:0] iTapSel;
  logic [SIZE-1:0]  Q;
  logic             oValid;
  logic [TAP_W-1:0] oOccupancy;

  modport master (
    output Enable, Flush, iValid, D, iTapSel,
    input  Q, oValid, oOccupancy
  );

  modport slave (
    input  Enable, Flush, iValid, D, iTapSel,
    output Q, oValid, oOccupancy
  );
endinterface

// File: rtl/ffd_delay_line_sync_reset.sv
// Enable-gated delay line of DEPTH stages with per-stage valid bits,
// a runtime output tap (0 = bypass), a flush control and a valid occupancy count.
// This design aligns FFT butterfly operands and twiddles that have different latencies.

// One stage of the line.
// Data shifts on Enable whether or not the sample is valid.
// Flush clears only the valid bit.
module ffd_delay_stage #(
  parameter int              SIZE        = 8,
  parameter logic [SIZE-1:0] RESET_VALUE = '0
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Enable,
  input  logic            Flush,
  input  logic [SIZE-1:0] din,
  input  logic            vin,
  output logic [SIZE-1:0] dout,
  output logic            vout
);
  // Priority order is reset, then flush (valid only), then enable, then hold.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      dout <= RESET_VALUE;
      vout <= 1'b0;
    end else begin
      if (Enable) dout <= din;
      if (Flush)       vout <= 1'b0;
      else if (Enable) vout <= vin;
    end
  end
endmodule

module ffd_delay_line_sync_reset #(
  parameter int              SIZE        = 8,
  parameter int              DEPTH       = 4,
  parameter logic [SIZE-1:0] RESET_VALUE = '0,
  parameter int              TAP_W       = $clog2(DEPTH + 1)
) (
  input  logic Clock,
  input  logic Reset,
  ffd_delay_line_sync_reset_if.slave bus
);
  localparam logic [TAP_W-1:0] MAX_TAP = TAP_W'(DEPTH);

  // Index 0 is the live input, so tap 0 falls out of the same mux as a bypass.
  logic [DEPTH:0][SIZE-1:0] dat_pipe;
  logic [DEPTH:0]           vld_pipe;
  logic [TAP_W-1:0]         tap;
  logic [TAP_W-1:0]         occ;

  assign dat_pipe[0] = bus.D;
  assign vld_pipe[0] = bus.iValid;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    ffd_delay_stage #(
      .SIZE        (SIZE),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .Clock  (Clock),
      .Reset  (Reset),
      .Enable (bus.Enable),
      .Flush  (bus.Flush),
      .din    (dat_pipe[k-1]),
      .vin    (vld_pipe[k-1]),
      .dout   (dat_pipe[k]),
      .vout   (vld_pipe[k])
    );
  end

  // Tap selects above DEPTH are clamped to the last stage.
  // Clamping also keeps the mux index within range.
  always_comb begin
    tap = bus.iTapSel;
    if (bus.iTapSel > MAX_TAP) tap = MAX_TAP;
  end

  assign bus.Q      = dat_pipe[tap];
  assign bus.oValid = vld_pipe[tap];

  // Count of valid stored stages. This count does not depend on the tap or the live input.
  always_comb begin
    occ = '0;
    for (int k = 1; k <= DEPTH; k++) occ = occ + TAP_W'(vld_pipe[k]);
  end

  assign bus.oOccupancy = occ;
endmodule

// File: tb/tb_ffd_delay_line_sync_reset.sv
// Scoreboard bench for the delay line.
// The reference model is a queue of samples: an enabled edge pushes D at the front and drops the oldest.
// A DEPTH=1 copy runs in lockstep and is checked at tap 1.
module tb_ffd_delay_line_sync_reset;
  localparam int          SIZE  = 8;
  localparam int          DEPTH = 4;
  localparam int          TAP_W = $clog2(DEPTH + 1);
  localparam logic [7:0]  RV    = 8'hA5;

  typedef struct { logic [7:0] d; logic v; } smp_t;
  typedef struct { logic [7:0] q; logic v; int occ; logic [7:0] q1; logic v1; } exp_t;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  ffd_delay_line_sync_reset_if #(.SIZE(SIZE), .DEPTH(DEPTH)) bus ();
  ffd_delay_line_sync_reset_if #(.SIZE(SIZE), .DEPTH(1))     bus1 ();

  ffd_delay_line_sync_reset #(.SIZE(SIZE), .DEPTH(DEPTH), .RESET_VALUE(RV)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  ffd_delay_line_sync_reset #(.SIZE(SIZE), .DEPTH(1), .RESET_VALUE(RV)) dut1 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus1)
  );

  assign bus1.Enable  = bus.Enable;
  assign bus1.Flush   = bus.Flush;
  assign bus1.iValid  = bus.iValid;
  assign bus1.D       = bus.D;
  assign bus1.iTapSel = 1'b1;

  smp_t line[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   known  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Apply the edge that just happened to the model, using the inputs that were present at that edge.
  task automatic model_edge();
    smp_t s;
    if (Reset) begin
      line.delete();
      for (int i = 0; i < DEPTH; i++) begin
        s.d = RV; s.v = 1'b0;
        line.push_back(s);
      end
      known = 1;
    end else begin
      if (bus.Enable) begin
        s.d = bus.D; s.v = bus.iValid;
        line.push_front(s);
        void'(line.pop_back());
      end
      if (bus.Flush) foreach (line[i]) line[i].v = 1'b0;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    int   t;
    t = (int'(bus.iTapSel) > DEPTH) ? DEPTH : int'(bus.iTapSel);
    if (t == 0) begin
      e.q = bus.D; e.v = bus.iValid;
    end else begin
      e.q = line[t-1].d; e.v = line[t-1].v;
    end
    e.occ = 0;
    foreach (line[i]) if (line[i].v) e.occ++;
    e.q1 = line[0].d;
    e.v1 = line[0].v;
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic en, input logic fl, input logic iv,
                      input logic [7:0] d, input int tap);
    @(posedge Clock);
    #1;
    model_edge();
    Reset       = r;
    bus.Enable  = en;
    bus.Flush   = fl;
    bus.iValid  = iv;
    bus.D       = d;
    bus.iTapSel = TAP_W'(tap);
    if (known) push_expected();
  endtask

  // Monitor: checks every presented output against the scoreboard, away from the active edge.
  always @(negedge Clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("q",        32'(bus.Q),          32'(e.q));
      chk("valid",    32'(bus.oValid),     32'(e.v));
      chk("occ",      32'(bus.oOccupancy), 32'(e.occ));
      chk("d1_q",     32'(bus1.Q),         32'(e.q1));
      chk("d1_valid", 32'(bus1.oValid),    32'(e.v1));
    end
  end

  initial begin
    smp_t s;
    for (int i = 0; i < DEPTH; i++) begin
      s.d = RV; s.v = 1'b0;
      line.push_back(s);
    end
    Reset = 1'b1; bus.Enable = 1'b1; bus.Flush = 1'b0; bus.iValid = 1'b1;
    bus.D = 8'hFF; bus.iTapSel = TAP_W'(1);

    // Reset held with D=FF and Enable high. Afterwards, look at every tap while the line holds.
    step(1, 1, 0, 1, 8'hFF, 2);
    step(0, 0, 0, 1, 8'hFF, 1);
    for (int t = 0; t <= 4; t++) step(0, 0, 0, 1, 8'hFF, t);

    // Fixed-latency stream at tap 3, followed by a 5-cycle stall and a resume.
    for (int i = 1; i <= 8; i++) step(0, 1, 0, 1, 8'(i), 3);
    for (int i = 0; i < 5; i++)  step(0, 0, 0, 1, 8'h9, 3);
    for (int i = 9; i <= 14; i++) step(0, 1, 0, 1, 8'(i), 3);

    // Push a valid, an invalid and a valid sample, watching them at tap 4.
    step(0, 1, 0, 1, 8'h10, 4);
    step(0, 1, 0, 0, 8'h20, 4);
    step(0, 1, 0, 1, 8'h30, 4);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'h00, 4);
    // Flush with Enable high while three stages are valid. Data still shifts.
    step(0, 1, 0, 1, 8'h41, 4);
    step(0, 1, 0, 1, 8'h42, 4);
    step(0, 1, 0, 1, 8'h43, 1);
    step(0, 1, 1, 1, 8'h44, 1);
    for (int t = 0; t <= 4; t++) step(0, 0, 0, 1, 8'h55, t);

    // Fill with 11, 22, 33, 44, then freeze and sweep the tap from 0 to 7.
    step(0, 1, 0, 1, 8'h11, 0);
    step(0, 1, 0, 1, 8'h22, 0);
    step(0, 1, 0, 1, 8'h33, 0);
    step(0, 1, 0, 1, 8'h44, 0);
    for (int t = 0; t <= 7; t++) step(0, 0, 0, 0, 8'h99, t);

    // Assert Reset, Flush and Enable together mid-stream. The 0x77 sample must not be stored.
    step(0, 1, 0, 1, 8'h01, 2);
    step(1, 1, 1, 1, 8'h77, 2);
    for (int t = 0; t <= 4; t++) step(0, 0, 0, 1, 8'h77, t);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0), 1'($urandom), 8'($urandom),
           int'($urandom_range(0, 7)));

    @(negedge Clock);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
